// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe
//   Pipelined fixed-point radix-2 DIT butterfly.
//     Y0 = A + B*W,  Y1 = A - B*W
//   The design has four stages and produces one butterfly per cycle. A
//   single global advance enable implements valid/ready backpressure.
//   Each sample carries its own inverse flag (conjugated twiddle) and its
//   own /2 scale flag. Outputs saturate to DW bits, and ovf is a sticky
//   saturation flag.
//
// Parameters
//   DW : data width, signed Q1.(DW-1)
//   TW : twiddle width, signed Q1.(TW-1), legal range 4..DW+8
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         input handshake (in_ready = advance)
//   in_a_re/im, in_b_re/im      operands A and B (DW bits each)
//   in_w_re/im                  twiddle W (TW bits each)
//   in_inv                      1 = use conj(W)
//   in_scale                    1 = divide both outputs by 2
//   out_valid / out_ready       output handshake
//   out_y0_re/im, out_y1_re/im  results (DW bits each)
//   ovf                         sticky saturation flag
//   ovf_clr                     synchronous clear of ovf (a set wins)
module fft_bfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a_re,
  input  logic [DW-1:0] in_a_im,
  input  logic [DW-1:0] in_b_re,
  input  logic [DW-1:0] in_b_im,
  input  logic [TW-1:0] in_w_re,
  input  logic [TW-1:0] in_w_im,
  input  logic          in_inv,
  input  logic          in_scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y0_re,
  output logic [DW-1:0] out_y0_im,
  output logic [DW-1:0] out_y1_re,
  output logic [DW-1:0] out_y1_im,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int PW = DW + TW;      // product width
  localparam int SW = PW + 1;       // sum/difference of two products
  localparam int XW = DW + 2;       // butterfly working width

  localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
  localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
  // Rounding constant 2^(TW-2): round-half-up before the >>> (TW-1)
  localparam logic signed [SW-1:0] RND   = {{(SW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [XW-1:0] Y_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] Y_MIN = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};

  // ------------------------------------------------------------------
  // Global advance: every stage moves together, and bubbles are kept.
  // ------------------------------------------------------------------
  logic advance;
  logic out_valid_reg;

  assign advance   = !out_valid_reg || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_reg;

  // Conjugate the twiddle on the way in. Negating the most negative value
  // would wrap, so it saturates to the most positive value instead.
  logic signed [TW-1:0] w_im_eff;
  always_comb begin
    w_im_eff = $signed(in_w_im);
    if (in_inv) begin
      w_im_eff = ($signed(in_w_im) == W_MIN) ? W_MAX : -$signed(in_w_im);
    end
  end

  // ------------------------------------------------------------------
  // S1: operand registers
  // ------------------------------------------------------------------
  logic                 s1_valid_reg;
  logic                 s1_scale_reg;
  logic signed [DW-1:0] s1_a_reg [2];
  logic signed [DW-1:0] s1_b_reg [2];
  logic signed [TW-1:0] s1_w_re_reg;
  logic signed [TW-1:0] s1_w_im_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_scale_reg <= 1'b0;
      s1_a_reg[0]  <= '0;
      s1_a_reg[1]  <= '0;
      s1_b_reg[0]  <= '0;
      s1_b_reg[1]  <= '0;
      s1_w_re_reg  <= '0;
      s1_w_im_reg  <= '0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s1_scale_reg <= in_scale;
      s1_a_reg[0]  <= $signed(in_a_re);
      s1_a_reg[1]  <= $signed(in_a_im);
      s1_b_reg[0]  <= $signed(in_b_re);
      s1_b_reg[1]  <= $signed(in_b_im);
      s1_w_re_reg  <= $signed(in_w_re);
      s1_w_im_reg  <= w_im_eff;
    end
  end

  // ------------------------------------------------------------------
  // S2: four full-precision products
  // ------------------------------------------------------------------
  logic                 s2_valid_reg;
  logic                 s2_scale_reg;
  logic signed [DW-1:0] s2_a_reg [2];
  logic signed [PW-1:0] s2_rr_reg;
  logic signed [PW-1:0] s2_ii_reg;
  logic signed [PW-1:0] s2_ri_reg;
  logic signed [PW-1:0] s2_ir_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_scale_reg <= 1'b0;
      s2_a_reg[0]  <= '0;
      s2_a_reg[1]  <= '0;
      s2_rr_reg    <= '0;
      s2_ii_reg    <= '0;
      s2_ri_reg    <= '0;
      s2_ir_reg    <= '0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      s2_scale_reg <= s1_scale_reg;
      s2_a_reg[0]  <= s1_a_reg[0];
      s2_a_reg[1]  <= s1_a_reg[1];
      s2_rr_reg    <= PW'(s1_b_reg[0]) * PW'(s1_w_re_reg);
      s2_ii_reg    <= PW'(s1_b_reg[1]) * PW'(s1_w_im_reg);
      s2_ri_reg    <= PW'(s1_b_reg[0]) * PW'(s1_w_im_reg);
      s2_ir_reg    <= PW'(s1_b_reg[1]) * PW'(s1_w_re_reg);
    end
  end

  // ------------------------------------------------------------------
  // S3: complex product combine, round back to Q1.(DW-1) in DW+2 bits.
  // |B*W| < 2^DW after rounding, so DW+2 bits cannot wrap.
  // ------------------------------------------------------------------
  logic                 s3_valid_reg;
  logic                 s3_scale_reg;
  logic signed [DW-1:0] s3_a_reg [2];
  logic signed [XW-1:0] s3_p_reg [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_reg <= 1'b0;
      s3_scale_reg <= 1'b0;
      s3_a_reg[0]  <= '0;
      s3_a_reg[1]  <= '0;
      s3_p_reg[0]  <= '0;
      s3_p_reg[1]  <= '0;
    end else if (advance) begin
      s3_valid_reg <= s2_valid_reg;
      s3_scale_reg <= s2_scale_reg;
      s3_a_reg[0]  <= s2_a_reg[0];
      s3_a_reg[1]  <= s2_a_reg[1];
      s3_p_reg[0]  <= XW'((SW'(s2_rr_reg) - SW'(s2_ii_reg) + RND) >>> (TW-1));
      s3_p_reg[1]  <= XW'((SW'(s2_ri_reg) + SW'(s2_ir_reg) + RND) >>> (TW-1));
    end
  end

  // ------------------------------------------------------------------
  // S4: add/subtract, optional /2, then saturate.
  // Component index: 0 = y0_re, 1 = y0_im, 2 = y1_re, 3 = y1_im
  // ------------------------------------------------------------------
  logic signed [XW-1:0] a_ext    [2];
  logic signed [XW-1:0] sum_x    [4];
  logic signed [XW-1:0] sum_inc  [4];
  logic signed [XW-1:0] scaled_x [4];
  logic        [DW-1:0] y_sat    [4];
  logic        [3:0]    sat_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sum
      assign a_ext[gi]    = XW'(s3_a_reg[gi]);
      assign sum_x[gi]    = a_ext[gi] + s3_p_reg[gi];
      assign sum_x[gi+2]  = a_ext[gi] - s3_p_reg[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_sat
      // The scale path is (x + 1) >>> 1, which rounds half up.
      assign sum_inc[gi]  = sum_x[gi] + ONE_X;
      assign scaled_x[gi] = s3_scale_reg ? (sum_inc[gi] >>> 1) : sum_x[gi];
      assign sat_hit[gi]  = (scaled_x[gi] > Y_MAX) || (scaled_x[gi] < Y_MIN);
      assign y_sat[gi]    = (scaled_x[gi] > Y_MAX) ? Y_MAX[DW-1:0] :
                            (scaled_x[gi] < Y_MIN) ? Y_MIN[DW-1:0] :
                                                     scaled_x[gi][DW-1:0];
    end
  endgenerate

  logic [DW-1:0] out_y_reg [4];
  logic          ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        out_y_reg[i] <= '0;
      end
    end else if (advance) begin
      out_valid_reg <= s3_valid_reg;
      for (int i = 0; i < 4; i++) begin
        out_y_reg[i] <= y_sat[i];
      end
    end
  end

  // A saturation in a valid sample that is entering the output register
  // has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (advance && s3_valid_reg && (|sat_hit)) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign out_y0_re = out_y_reg[0];
  assign out_y0_im = out_y_reg[1];
  assign out_y1_re = out_y_reg[2];
  assign out_y1_im = out_y_reg[3];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe
//   Directed-vector bench for fft_bfly_pipe with DW = TW = 16. It covers:
//   hand-computed butterflies, saturation and scaling, inverse mode with
//   twiddle edge cases, and ovf set/clear priority. It also covers reset
//   with samples in flight and a backpressure burst, which is checked
//   against a behavioural model.
module tb_fft_bfly_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a_re, in_a_im, in_b_re, in_b_im, in_w_re, in_w_im;
  logic        in_inv, in_scale;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y0_re, out_y0_im, out_y1_re, out_y1_im;
  logic        ovf;
  logic        ovf_clr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fft_bfly_pipe #(.DW(16), .TW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a_re   (in_a_re),
    .in_a_im   (in_a_im),
    .in_b_re   (in_b_re),
    .in_b_im   (in_b_im),
    .in_w_re   (in_w_re),
    .in_w_im   (in_w_im),
    .in_inv    (in_inv),
    .in_scale  (in_scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y0_re (out_y0_re),
    .out_y0_im (out_y0_im),
    .out_y1_re (out_y1_re),
    .out_y1_im (out_y1_im),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] y_bus();
    return {out_y0_re, out_y0_im, out_y1_re, out_y1_im};
  endfunction

  // Behavioural butterfly used for the random backpressure burst
  function automatic logic [63:0] bfly_model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                             input logic inv, scale);
    longint a_r, a_i, b_r, b_i, w_r, w_i, p_r, p_i;
    longint y [4];
    logic [15:0] r [4];
    a_r = longint'($signed(ar));
    a_i = longint'($signed(ai));
    b_r = longint'($signed(br));
    b_i = longint'($signed(bi));
    w_r = longint'($signed(wr));
    w_i = longint'($signed(wi));
    if (inv) w_i = (w_i == -32768) ? 32767 : -w_i;
    p_r = (b_r * w_r - b_i * w_i + 16384) >>> 15;
    p_i = (b_r * w_i + b_i * w_r + 16384) >>> 15;
    y[0] = a_r + p_r;
    y[1] = a_i + p_i;
    y[2] = a_r - p_r;
    y[3] = a_i - p_i;
    for (int i = 0; i < 4; i++) begin
      if (scale) y[i] = (y[i] + 1) >>> 1;
      if (y[i] > 32767) y[i] = 32767;
      if (y[i] < -32768) y[i] = -32768;
      r[i] = y[i][15:0];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  task automatic drive(input logic [15:0] ar, ai, br, bi, wr, wi, input logic inv, scale);
    in_a_re = ar; in_a_im = ai; in_b_re = br; in_b_im = bi;
    in_w_re = wr; in_w_im = wi; in_inv = inv; in_scale = scale;
  endtask

  // Present one sample with out_ready high and check the latency, the
  // result and ovf. When clr_at_out is set, ovf_clr is raised on the
  // edge where the result enters the output register.
  task automatic send_dir(input string tag,
                          input logic [15:0] ar, ai, br, bi, wr, wi,
                          input logic inv, scale,
                          input logic [63:0] exp_y, input logic exp_ovf,
                          input logic clr_at_out);
    out_ready = 1'b1;
    drive(ar, ai, br, bi, wr, wi, inv, scale);
    in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, " early"}, 64'(out_valid), 64'(0));
    if (clr_at_out) ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check({tag, " out_valid"}, 64'(out_valid), 64'(1));
    check({tag, " y"}, y_bus(), exp_y);
    check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    $display("txn %s: y0=(%h,%h) y1=(%h,%h) ovf=%0d", tag,
             out_y0_re, out_y0_im, out_y1_re, out_y1_im, ovf);
  endtask

  typedef struct {
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic        inv, scale;
  } smp_t;

  initial begin
    smp_t        vec [10];
    logic [63:0] sb [$];
    logic [63:0] exp_y;
    int          idx, rcv;
    logic        extra_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    #3;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst ovf", 64'(ovf), 64'(0));
    check("rst y", y_bus(), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic butterfly
    send_dir("basic", 16'h1000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
             {16'h3000, 16'h0000, 16'hF000, 16'h0000}, 1'b0, 1'b0);
    // Saturation, then clear ovf alone
    send_dir("sat", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
             {16'h7FFF, 16'h0000, 16'h0001, 16'h0000}, 1'b1, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr alone", 64'(ovf), 64'(0));
    send_dir("sat scaled", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b1,
             {16'h7000, 16'h0000, 16'h0001, 16'h0000}, 1'b0, 1'b0);
    // Inverse mode
    send_dir("fwd jw", 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 1'b0, 1'b0,
             {16'hC001, 16'h0000, 16'h3FFF, 16'h0000}, 1'b0, 1'b0);
    send_dir("inv jw", 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 1'b1, 1'b0,
             {16'h4000, 16'h0000, 16'hC000, 16'h0000}, 1'b0, 1'b0);
    send_dir("inv wmin", 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h8000, 1'b1, 1'b0,
             {16'hC001, 16'h0000, 16'h3FFF, 16'h0000}, 1'b0, 1'b0);
    // A set beats a simultaneous clear, and a later clear alone works
    send_dir("sat+clr", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
             {16'h7FFF, 16'h0000, 16'h0001, 16'h0000}, 1'b1, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr after set", 64'(ovf), 64'(0));
    send_dir("sat again", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
             {16'h7FFF, 16'h0000, 16'h0001, 16'h0000}, 1'b1, 1'b0);
    tick();

    // Reset with three samples in flight: the first one is visible, and
    // two more are still in the pipe.
    drive(16'h1000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick();
    check("pre-rst valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 64'(out_valid), 64'(0));
    check("mid-rst y", y_bus(), 64'h0);
    check("mid-rst ovf", 64'(ovf), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    extra_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) extra_valid = 1'b1;
    end
    check("post-rst no ghost", 64'(extra_valid), 64'(0));
    send_dir("post-rst", 16'h1000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
             {16'h3000, 16'h0000, 16'hF000, 16'h0000}, 1'b0, 1'b0);
    tick(); tick();

    // Backpressure burst: 10 back-to-back samples, out_ready low in cycles 3..8
    for (int i = 0; i < 10; i++) begin
      vec[i].ar = 16'($urandom); vec[i].ai = 16'($urandom);
      vec[i].br = 16'($urandom); vec[i].bi = 16'($urandom);
      vec[i].wr = 16'($urandom); vec[i].wi = 16'($urandom);
      vec[i].inv = 1'($urandom); vec[i].scale = 1'($urandom);
    end
    idx = 0;
    rcv = 0;
    for (int c = 0; c < 60 && rcv < 10; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      if (idx < 10) begin
        drive(vec[idx].ar, vec[idx].ai, vec[idx].br, vec[idx].bi,
              vec[idx].wr, vec[idx].wi, vec[idx].inv, vec[idx].scale);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c <= 9) check($sformatf("bp in_ready c%0d", c), 64'(in_ready),
                        64'(!(c >= 4 && c <= 8)));
      if (in_valid && in_ready) begin
        sb.push_back(bfly_model(vec[idx].ar, vec[idx].ai, vec[idx].br, vec[idx].bi,
                                vec[idx].wr, vec[idx].wi, vec[idx].inv, vec[idx].scale));
        idx++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("bp unexpected output", 64'(1), 64'(0));
        end else begin
          exp_y = sb.pop_front();
          check($sformatf("bp y%0d", rcv), y_bus(), exp_y);
          $display("txn bp%0d: y0=(%h,%h) y1=(%h,%h)", rcv,
                   out_y0_re, out_y0_im, out_y1_re, out_y1_im);
        end
        rcv++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp received", 64'(rcv), 64'(10));
    check("bp queue empty", 64'(sb.size()), 64'(0));
    tick(); tick();
    check("bp no repeat", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
